// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
// Segment geometry and bus offsets are computed here so every file agrees.
package adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic                 ovf;
    logic                 co;
    logic [DEF_WIDTH-1:0] s;
  } res_t;

  function automatic int seg_width(
    input int width,
    input int stages
  );
    return width / stages;
  endfunction

  function automatic bit seg_ok(
    input int width,
    input int stages
  );
    return (width >= 2) && (stages >= 1) &&
           (stages <= width) &&
           ((width % stages) == 0);
  endfunction

  // Node n of the skewed datapath is 2*width - n*seg bits wide.
  function automatic int node_off(
    input int width,
    input int seg,
    input int n
  );
    return 2 * width * n - (seg * n * (n - 1)) / 2;
  endfunction

endpackage

// File: rtl/adder_pipe_seg.sv
// One carry-chain segment: SEG-bit slice add, stage register and valid bit.
// Data bus layout is {b_hi, a_hi, sum_lo}, sum_lo at the LSB end.
module adder_pipe_seg
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int K     = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  input  logic adv_next_i,
  input  logic cin_i,
  input  logic [K*SEG+2*(WIDTH-K*SEG)-1:0] d_i,
  output logic valid_o,
  output logic cout_o,
  output logic ovf_o,
  output logic [K*SEG+2*(WIDTH-K*SEG)-SEG-1:0] d_o
);

  localparam int LO = K * SEG;
  localparam int R  = WIDTH - LO;
  localparam int IW = LO + 2 * R;
  localparam int OW = IW - SEG;

  logic [SEG-1:0] a_seg;
  logic [SEG-1:0] b_seg;
  logic [SEG-1:0] sum;
  logic           c_out;
  logic [OW-1:0]  d_d;
  logic [OW-1:0]  d_q;
  logic           valid_q;
  logic           c_q;
  logic           adv;

  assign a_seg = d_i[LO +: SEG];
  assign b_seg = d_i[LO+R +: SEG];

  assign {c_out, sum} = {1'b0, a_seg}
                      + {1'b0, b_seg}
                      + {{SEG{1'b0}}, cin_i};

  // Sum joins the low end; the remaining operands shift down one slice.
  for (genvar i = 0; i < OW; i++) begin : g_bit
    if (i < LO) begin : g_lo
      assign d_d[i] = d_i[i];
    end else if (i < LO + SEG) begin : g_sum
      assign d_d[i] = sum[i-LO];
    end else if (i < LO + R) begin : g_ahi
      assign d_d[i] = d_i[i];
    end else begin : g_bhi
      assign d_d[i] = d_i[i+SEG];
    end
  end

  assign adv = !valid_q || adv_next_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      c_q     <= 1'b0;
      d_q     <= '0;
    end else if (adv) begin
      valid_q <= valid_i;
      if (valid_i) begin
        c_q <= c_out;
        d_q <= d_d;
      end
    end
  end

  if (LAST) begin : g_ovf
    logic c_msb;
    logic ovf_q;

    assign c_msb = a_seg[SEG-1] ^ b_seg[SEG-1] ^ sum[SEG-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_q <= 1'b0;
      end else if (adv && valid_i) begin
        ovf_q <= c_msb ^ c_out;
      end
    end

    assign ovf_o = ovf_q;
  end else begin : g_no_ovf
    assign ovf_o = 1'b0;
  end

  assign valid_o = valid_q;
  assign cout_o  = c_q;
  assign d_o     = d_q;

endmodule

// File: rtl/adder_pipelined.sv
// Pipelined add/subtract with valid/ready on both sides.
// Carry chain split into STAGES registered segments over a skewed datapath.
module adder_pipelined
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SEG   = seg_width(WIDTH, STAGES);
  localparam int BUS_W = node_off(WIDTH, SEG, STAGES + 1);
  localparam int S_OFF = node_off(WIDTH, SEG, STAGES);

  if (!seg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("adder_pipelined: STAGES must divide WIDTH, WIDTH >= 2");
  end

  logic             op_sub;
  logic             ci_eff;
  logic [WIDTH-1:0] b_eff;
  logic [BUS_W-1:0] dbus;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] cry;
  logic [STAGES-1:0] ovf_w;
  logic [STAGES-1:0] adv_nx;

  assign op_sub = (sub == MODE_SUB);
  assign b_eff  = op_sub ? ~b : b;
  assign ci_eff = op_sub ? ~ci : ci;

  assign dbus[0 +: 2*WIDTH] = {b_eff, a};

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IO = node_off(WIDTH, SEG, k);
    localparam int OO = node_off(WIDTH, SEG, k + 1);
    localparam int IW = 2 * WIDTH - k * SEG;
    localparam int OW = IW - SEG;

    logic v_in;
    logic c_in;

    if (k == 0) begin : g_first
      assign v_in = in_valid;
      assign c_in = ci_eff;
    end else begin : g_next
      assign v_in = vld[k-1];
      assign c_in = cry[k-1];
    end

    // A stage may advance unless every stage after it is full and stalled.
    if (k == STAGES - 1) begin : g_out
      assign adv_nx[k] = out_ready;
    end else begin : g_mid
      assign adv_nx[k] = out_ready | ~&vld[STAGES-1:k+1];
    end

    adder_pipe_seg #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .K     (k),
      .LAST  (k == STAGES - 1)
    ) u_seg (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (v_in),
      .adv_next_i (adv_nx[k]),
      .cin_i      (c_in),
      .d_i        (dbus[IO +: IW]),
      .valid_o    (vld[k]),
      .cout_o     (cry[k]),
      .ovf_o      (ovf_w[k]),
      .d_o        (dbus[OO +: OW])
    );
  end

  assign in_ready  = out_ready | ~&vld;
  assign out_valid = vld[STAGES-1];
  assign s         = dbus[S_OFF +: WIDTH];
  assign co        = cry[STAGES-1];
  // Only the MSB segment drives a nonzero overflow flag.
  assign ovf       = |ovf_w;

endmodule

// File: doc/adder_pipelined.md
Name: adder_pipelined

Overview:
Parametrised, pipelined add/subtract unit with valid/ready handshakes on input and output. It is the successor to the fixed 32-bit adder followed by a single output register. The carry chain is split into STAGES equal segments, each registered, so throughput is one operation per cycle at any WIDTH. It sits between an operand producer and a result consumer, and either side may stall.

Parameters:
WIDTH, 32, operand/sum width in bits; must be ≥2.
STAGES, 4, number of pipeline segments; must divide WIDTH exactly, range 1..WIDTH. SEG = WIDTH/STAGES.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operands a, b, ci, sub are valid this cycle
in_ready  out  1  unit accepts operands this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
ci  in  1  carry-in (add) / borrow-in (sub)
sub  in  1  0: add, 1: subtract
out_valid  out  1  s, co, ovf are valid
out_ready  in  1  consumer takes the result this cycle
s  out  WIDTH  sum/difference
co  out  1  raw carry out of MSB (for sub: 1 = no borrow)
ovf  out  1  two's-complement overflow

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous and active-low. When rst_n is low, every stage valid bit clears immediately, out_valid=0, s=0, co=0, ovf=0. in_ready follows the combinational rule below, so it reads 1 during reset when there is no stall.
- Arithmetic:
  - sub=0: {co,s} = a + b + ci.
  - sub=1: s = a + ~b + ~ci, which is a − b − ci mod 2^WIDTH. co is the raw carry of that sum.
  - ovf = carry into MSB XOR carry out of MSB.
- Pipeline:
  - Stage k (0..STAGES−1) adds bits [k*SEG +: SEG] using the registered carry from stage k−1. Stage 0 uses the effective carry-in (ci, or ~ci when sub=1).
  - Higher operand segments and the already-computed lower sum segments travel forward in stage registers (skewed datapath).
  - The inversion of b is applied at acceptance; sub is not stored past stage 0.
- Handshake:
  - A transfer occurs when in_valid && in_ready, or when out_valid && out_ready.
  - Stage k advances when its successor is empty or advancing. Output stage advances when out_ready=1 or out_valid=0.
  - in_ready = stage-0 advance condition, derived combinationally from out_ready through the valid bits. Bubbles collapse.
- Latency: a result is presented STAGES cycles after acceptance with no stall. With out_ready held at 1, throughput is 1 per cycle.
- Stall: while out_valid && !out_ready, s/co/ovf stay stable and no stage overwrites occupied data. Order is preserved, with no loss and no duplication.
- Simultaneous accept and emit in the same cycle on a full pipeline is legal and keeps it full.
- in_valid=0 inserts a bubble; unaccepted inputs are ignored.
- Reset mid-operation discards all in-flight operations; none emerge after release.
- Wrap-around: the sum is mod 2^WIDTH, and overflow information is carried only in co/ovf.

Decomposition:
- Shared package adder_pkg:
  - localparam-style helper function seg_width(WIDTH,STAGES) with an elaboration check that the division is exact.
  - Result record typedef {ovf, co, s}.
  - ADD/SUB mode constants.
- One sub-module, adder_pipe_seg: SEG-bit slice adder plus stage register, valid bit and advance logic. It is instantiated STAGES times via generate.
- Top level: operand conditioning, skew registers, output mapping.

Test Plan:
1. WIDTH=32, STAGES=4; a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0, out_ready=1 -> exactly 4 cycles later out_valid=1, s=0x00000000, co=1, ovf=0.
2. sub=1 cases:
   - a=5, b=7, ci=0 -> s=0xFFFFFFFE, co=0, ovf=0.
   - a=0x80000000, b=1, ci=0 -> s=0x7FFFFFFF, co=1, ovf=1.
   - a=10, b=3, ci=1 -> s=6, co=1.
3. 1000 back-to-back random {a,b,ci,sub} with out_ready=1 -> in_ready constantly 1, one result per cycle, each matching a bit-exact model in order.
4. Fill the pipeline, then hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops after 4 accepts, s/co/ovf stable, no loss or duplication. Release -> 1 result per cycle and in_ready reasserts the same cycle.
5. Three operations in flight, assert rst_n low mid-cycle -> out_valid and outputs go to 0 immediately without a clock edge. After release no stale result appears and the next operation has latency 4.
6. Rebuild with STAGES=1 and STAGES=32 (WIDTH=32), and with WIDTH=8 STAGES=2 -> latencies 1, 32 and 2. Carry ripple 0xFF+0x01 gives s=0x00, co=1 in the 8-bit build.
